// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a wait-handshake refill port.
// Optional feature: define ICACHE_BYPASS_EN to forward refill data to the fetch in the fill cycle.
module icache #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 26
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iflush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int unsigned Frames = 1 << IDX_W;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e                   state_q;
    logic [29:0]              fill_q;
    logic [Frames-1:0]        valid_q;
    logic [TAG_W-1:0]         tag_q  [Frames];
    logic [31:0]              data_q [Frames];

    logic [IDX_W-1:0]         req_idx;
    logic [TAG_W-1:0]         req_tag;
    logic [IDX_W-1:0]         fill_idx;
    logic                     lookup_hit;
    logic                     fill_done;

    assign req_idx    = imemaddr[IDX_W+1:2];
    assign req_tag    = imemaddr[31:IDX_W+2];
    assign fill_idx   = fill_q[IDX_W-1:0];
    assign lookup_hit = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign fill_done  = (state_q == StFill) & ~iwait;

`ifdef ICACHE_BYPASS_EN
    logic unused_bits;
    assign unused_bits = ^imemaddr[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{imemaddr[1:0], iload};
`endif

    always_comb begin
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        case (state_q)
            StIdle: begin
                ihit = lookup_hit & ~iflush;
                if (ihit) imemload = data_q[req_idx];
            end
            StFill: begin
                iREN  = 1'b1;
                iaddr = {fill_q, 2'b00};
`ifdef ICACHE_BYPASS_EN
                // Forward only when the requester still wants exactly the word being filled.
                if (!iwait && imemREN && (imemaddr[31:2] == fill_q) && !iflush) begin
                    ihit     = 1'b1;
                    imemload = iload;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            fill_q  <= '0;
            valid_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (iflush) begin
                        valid_q <= '0;
                    end else if (imemREN && !lookup_hit) begin
                        fill_q  <= imemaddr[31:2];
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    // A flush landing on the completion cycle leaves the new frame invalid.
                    if (iflush) valid_q <= '0;
                    if (!iwait) begin
                        if (!iflush) valid_q[fill_idx] <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag/data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[fill_idx]  <= fill_q[29:IDX_W];
            data_q[fill_idx] <= iload;
        end
    end

endmodule
